// File: rtl/picorv_print_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : picorv_print_pkg
//  Description : Shared constants and types for the print_out word packer.
//  Revision    : 1.0  initial release
// ============================================================================
package picorv_print_pkg;

    localparam int         PRINT_W       = 49;
    localparam int         PRINT_STB_BIT = 48;
    localparam logic [7:0] CHAR_NL       = 8'h0A;
    localparam logic [7:0] CHAR_PAD      = 8'h00;

    // Packer state: no bytes collected yet / 1..3 bytes collected
    typedef enum logic [0:0] {
        PK_EMPTY   = 1'b0,
        PK_PARTIAL = 1'b1
    } pk_state_t;

endpackage
`default_nettype wire

// File: rtl/picorv_print_packer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : print_word_fifo
//  Description : 32-bit first-word-fall-through synchronous FIFO. The head
//                word is presented combinationally from storage; when empty
//                the output holds the most recently popped word (0 after
//                reset). A push while full is accepted only if a pop happens
//                in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module print_word_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [31:0] r_hold;
    logic        w_do_pop;
    logic        w_do_push;

    // Extra MSB on each pointer distinguishes full from empty
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = empty ? r_hold : r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update and capture of the last popped word for the idle output
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_hold   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_hold   <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/picorv_print_packer.sv
`default_nettype none
// ============================================================================
//  Module      : picorv_print_packer
//  Description : Collects characters from the core's print_out channel,
//                packs them little-endian into 32-bit words (completed by
//                four bytes, a newline or an idle timeout) and streams the
//                words out through a FWFT FIFO with valid/ready handshake.
//                Words arriving at a full FIFO are dropped and counted.
//  Revision    : 1.0  initial release
// ============================================================================
module picorv_print_packer
    import picorv_print_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int FLUSH_CYCLES = 64,
    parameter int DROP_W       = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [PRINT_W-1:0] print_in,
    output logic               val_out,
    input  logic               ready_downward,
    output logic [31:0]        dout,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_cnt
);

    localparam int               TMR_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(FLUSH_CYCLES - 1);

    pk_state_t         r_state;
    pk_state_t         w_state_next;
    logic [1:0]        r_byte_cnt;
    logic [1:0]        w_byte_cnt_next;
    logic [31:0]       r_word;
    logic [31:0]       w_word_next;
    logic [31:0]       w_word_filled;
    logic [31:0]       w_push_word;
    logic [TMR_W-1:0]  r_timer;
    logic [TMR_W-1:0]  w_timer_next;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_strobe;
    logic [7:0]        w_char;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_overflow;
    logic              w_unused_print;

    assign w_strobe       = print_in[PRINT_STB_BIT];
    assign w_char         = print_in[7:0];
    assign w_unused_print = ^print_in[PRINT_STB_BIT-1:8];

    // Current word with the incoming char dropped into the next free byte
    always_comb begin
        w_word_filled                     = r_word;
        w_word_filled[r_byte_cnt*8 +: 8]  = w_char;
    end

    // Packer next-state: a strobe always wins over an expiring idle timer
    always_comb begin
        w_state_next    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_word_next     = r_word;
        w_timer_next    = r_timer;
        w_push          = 1'b0;
        w_push_word     = r_word;
        if (w_strobe) begin
            w_timer_next = '0;
            if ((r_byte_cnt == 2'd3) || (w_char == CHAR_NL)) begin
                w_push          = 1'b1;
                w_push_word     = w_word_filled;
                w_word_next     = {4{CHAR_PAD}};
                w_byte_cnt_next = 2'd0;
                w_state_next    = PK_EMPTY;
            end else begin
                w_word_next     = w_word_filled;
                w_byte_cnt_next = r_byte_cnt + 2'd1;
                w_state_next    = PK_PARTIAL;
            end
        end else if (r_state == PK_PARTIAL) begin
            if (r_timer == C_TMR_LAST) begin
                w_push          = 1'b1;
                w_push_word     = r_word;
                w_word_next     = {4{CHAR_PAD}};
                w_byte_cnt_next = 2'd0;
                w_timer_next    = '0;
                w_state_next    = PK_EMPTY;
            end else begin
                w_timer_next    = r_timer + TMR_W'(1);
            end
        end
    end

    // Packer state, partial word, byte count and idle timer registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= PK_EMPTY;
            r_byte_cnt <= 2'd0;
            r_word     <= '0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_word     <= w_word_next;
            r_timer    <= w_timer_next;
        end
    end

    assign w_pop  = !w_fifo_empty && ready_downward;
    assign w_drop = w_push && w_fifo_full && !w_pop;

    // Saturating drop counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != {DROP_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    print_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_push),
        .push_data (w_push_word),
        .pop       (w_pop),
        .dout      (dout),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign val_out  = !w_fifo_empty;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_picorv_print_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_picorv_print_packer
//  Description : Directed self-checking bench for picorv_print_packer with
//                FIFO_DEPTH=4 and FLUSH_CYCLES=16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_picorv_print_packer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [48:0] print_in;
    logic        val_out;
    logic        ready_downward;
    logic [31:0] dout;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_vec = 0;
    int n_mis = 0;

    picorv_print_packer #(
        .FIFO_DEPTH   (4),
        .FLUSH_CYCLES (16),
        .DROP_W       (16)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .print_in       (print_in),
        .val_out        (val_out),
        .ready_downward (ready_downward),
        .dout           (dout),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_char(input logic [7:0] c);
        print_in = {1'b1, 40'h0, c};
        tick();
        print_in = '0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_char(w[i*8 +: 8]);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic seen;
        resetn         = 1'b0;
        ready_downward = 1'b0;
        print_in       = '0;

        // 1: reset state
        idle(3);
        check("rst_val",      {31'b0, val_out},  32'd0);
        check("rst_dout",     dout,              32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_drop",     {16'b0, drop_cnt}, 32'd0);
        resetn = 1'b1;
        tick();

        // 2: four chars make one word, visible the cycle after the 4th edge
        ready_downward = 1'b1;
        send_char("A"); send_char("B"); send_char("C");
        check("abc_noval", {31'b0, val_out}, 32'd0);
        send_char("D");
        check("abcd_val",  {31'b0, val_out}, 32'd1);
        check("abcd_dout", dout, 32'h44434241);
        tick();
        check("abcd_popped", {31'b0, val_out}, 32'd0);
        check("abcd_hold",   dout, 32'h44434241);

        // 3: newline terminates a short word, no timeout word afterwards
        send_char("H"); send_char("i"); send_char(8'h0A);
        check("nl_val",  {31'b0, val_out}, 32'd1);
        check("nl_dout", dout, 32'h000A6948);
        tick();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (val_out) seen = 1'b1;
            tick();
        end
        check("nl_no_flush", {31'b0, seen}, 32'd0);

        // 3b: newline as 4th char yields one word and no empty follow-up
        send_char("a"); send_char("b"); send_char("c"); send_char(8'h0A);
        check("nl4_dout", dout, 32'h0A636261);
        tick();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (val_out) seen = 1'b1;
            tick();
        end
        check("nl4_no_extra", {31'b0, seen}, 32'd0);

        // 4: idle timeout flushes exactly 16 cycles after the last char
        send_char("x"); send_char("y");
        idle(15);
        check("flush_early", {31'b0, val_out}, 32'd0);
        tick();
        check("flush_val",  {31'b0, val_out}, 32'd1);
        check("flush_dout", dout, 32'h00007978);
        tick();

        // 4b: a char on the expiring cycle wins, timer restarts
        send_char("x"); send_char("y");
        idle(15);
        send_char("z");
        check("flush_char_wins", {31'b0, val_out}, 32'd0);
        idle(15);
        check("flush2_early", {31'b0, val_out}, 32'd0);
        tick();
        check("flush2_val",  {31'b0, val_out}, 32'd1);
        check("flush2_dout", dout, 32'h007A7978);
        tick();

        // 5: overflow with a 4-deep FIFO, then push-with-pop while full
        ready_downward = 1'b0;
        send_word(32'h23222120);
        send_word(32'h27262524);
        send_word(32'h2B2A2928);
        send_word(32'h2F2E2D2C);
        send_word(32'h33323130);
        send_word(32'h37363534);
        check("ovf_drop",  {16'b0, drop_cnt}, 32'd2);
        check("ovf_flag",  {31'b0, overflow}, 32'd1);
        check("ovf_head",  dout, 32'h23222120);
        tick();
        check("ovf_stable", dout, 32'h23222120);
        send_char(8'h40); send_char(8'h41); send_char(8'h42);
        ready_downward = 1'b1;
        send_char(8'h43);
        check("fullpp_drop", {16'b0, drop_cnt}, 32'd2);
        check("drain_w1", dout, 32'h27262524);
        tick();
        check("drain_w2", dout, 32'h2B2A2928);
        tick();
        check("drain_w3", dout, 32'h2F2E2D2C);
        tick();
        check("drain_w6", dout, 32'h43424140);
        tick();
        check("drain_empty", {31'b0, val_out}, 32'd0);

        // 6: reset mid-word discards the partial word and clears counters
        send_char("q"); send_char("r");
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("rst2_val",  {31'b0, val_out},  32'd0);
        check("rst2_drop", {16'b0, drop_cnt}, 32'd0);
        check("rst2_ovf",  {31'b0, overflow}, 32'd0);
        send_char("A"); send_char("B"); send_char("C"); send_char("D");
        check("rst2_dout", dout, 32'h44434241);
        tick();
        check("rst2_once", {31'b0, val_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
